mmu_arbiter: RTL
================

Name: mmu_arbiter

Overview:
- Two-port arbiter and sequencer in front of the mmu. It shares one mmu between the instruction-fetch port (if_*, word reads only) and the data load/store port (d_*).
- It serialises requests and pulses the mmu enables. It tracks mmu_ready to detect completion, waits for data_out to settle, and returns a one-cycle ack with read data.
- The data port has priority, bounded by a starvation limit. A watchdog flags a stuck mmu.

Parameters:
- READ_SETTLE, 2: cycles to wait after mmu_ready returns high before sampling mmu_data_out (covers the mmu output register stages).
- MAX_DATA_STREAK, 4: maximum consecutive data grants while if_req is pending; the next grant then goes to fetch.
- TIMEOUT, 15: maximum cycles from ISSUE to completion before an error response.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-low reset
- if_req  in  1  fetch request; held with if_addr until if_ack
- if_addr  in  32  fetch address
- if_ack  out  1  one-cycle completion pulse
- if_rdata  out  32  fetched word; valid while if_ack=1
- d_req  in  1  data request; held with d_* fields until d_ack
- d_we  in  1  1 = store, 0 = load
- d_signed  in  1  load sign-extend
- d_width  in  2  0 = byte, 1 = half, 2 = 3-byte, 3 = word (mmu encoding)
- d_addr  in  32  data address
- d_wdata  in  32  store data
- d_ack  out  1  one-cycle completion pulse
- d_rdata  out  32  load data; valid while d_ack=1; 0 for stores
- err  out  1  pulses together with the ack on a watchdog timeout
- mmu_write_enable  out  1  to mmu write_enable
- mmu_read_enable  out  1  to mmu read_enable
- mmu_signed  out  1  to mmu mem_signed
- mmu_width  out  2  to mmu mem_width
- mmu_address  out  32  to mmu address
- mmu_data_in  out  32  to mmu data_in
- mmu_data_out  in  32  from mmu data_out
- mmu_ready  in  1  from mmu mem_ready; 1 = mmu idle

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, streak=0, timer=0.
  - All outputs 0.
  - A transaction in flight is abandoned with no ack.
  - After reset is released, arbitration starts in the first IDLE cycle.
- All outputs are registered.
- States: IDLE, ISSUE, WAIT_BUSY, WAIT_READY, SETTLE, RESP.
- IDLE:
  - Acts only when mmu_ready=1 and at least one req is high.
  - Winner selection: fetch wins if d_req=0, or if if_req=1 and streak>=MAX_DATA_STREAK; otherwise data wins.
  - Latch the winner's fields into the mmu_* registers.
  - Fetch winner drives width=3, signed=0, we=0, data_in=0.
  - Streak: a data grant increments it only if if_req=1 (saturating); a data grant with if_req=0 or any fetch grant clears it to 0.
  - Next state ISSUE.
- ISSUE:
  - Assert exactly one of mmu_read_enable/mmu_write_enable for this single cycle; timer=0.
  - Next state WAIT_BUSY.
- WAIT_BUSY:
  - Enables are 0.
  - mmu_ready=0 → WAIT_READY.
- WAIT_READY:
  - mmu_ready=1 and load/fetch → SETTLE with count=READ_SETTLE.
  - mmu_ready=1 and store → RESP.
  - If READ_SETTLE=0, go straight to RESP and sample mmu_data_out on that edge.
- SETTLE:
  - Decrement count each cycle.
  - On the edge where count reaches 0, capture mmu_data_out into the winner's rdata register and go to RESP.
- RESP:
  - Winner's ack=1 for exactly one cycle; the other ack stays 0.
  - Next state IDLE; ack returns to 0.
  - The requester drops req on the edge after it sees ack, so IDLE sees req low. A req still high in the IDLE cycle after RESP is a new request.
- Watchdog:
  - timer increments in WAIT_BUSY/WAIT_READY/SETTLE.
  - When timer reaches TIMEOUT, go to RESP with err=1, rdata=0, ack=1.
  - Timeout takes precedence over completion on the same edge.
- Address, width and data outputs hold their latched values between transactions; only the enables are pulsed.
- Request inputs are ignored outside IDLE; changes to them mid-transaction have no effect.
- Fixed latency, fault-free mmu: an aligned load/fetch takes 1 (IDLE) + 1 (ISSUE) + ≥1 (WAIT_BUSY) + ≥1 (WAIT_READY) + READ_SETTLE + 1 (RESP) cycles.

Test Plan:
- Reset mid-transaction: pull reset low during WAIT_READY → all outputs 0 immediately, no ack; after release, a fresh d_req is served normally.
- Fetch alone: if_req, if_addr=0x00000010 → one mmu_read_enable pulse, width=3, address=0x10; if_ack one cycle with if_rdata equal to the value on mmu_data_out READ_SETTLE cycles after mmu_ready rose; d_ack stays 0.
- Store: d_we=1, d_width=0, d_addr=0x01000003, d_wdata=0xA5 → one mmu_write_enable pulse, no mmu_read_enable; d_ack with d_rdata=0; no SETTLE cycles.
- Contention: d_req and if_req both held continuously, each requester re-requesting right after its ack → grant order D,D,D,D,I,D,D,D,D,I.
- Timeout: mmu model keeps mmu_ready=0 after ISSUE → exactly 15 cycles later d_ack=1 and err=1 with d_rdata=0, then IDLE; the next request completes normally.
- Signed load passthrough: d_signed=1, d_width=1 → mmu_signed=1, mmu_width=1; d_rdata equals the mmu_data_out value at the capture edge, e.g. 0xFFFF8001.

Source files
------------

// File: rtl/mmu_arbiter_if.sv
// Request/response and mmu-side signals shared between the two requesters, the arbiter and the mmu.
// The slave modport is the arbiter's view; master is the environment (requesters plus mmu).
interface mmu_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_ack;
  logic [31:0] if_rdata;

  logic        d_req;
  logic        d_we;
  logic        d_signed;
  logic [1:0]  d_width;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_ack;
  logic [31:0] d_rdata;
  logic        err;

  logic        mmu_write_enable;
  logic        mmu_read_enable;
  logic        mmu_signed;
  logic [1:0]  mmu_width;
  logic [31:0] mmu_address;
  logic [31:0] mmu_data_in;
  logic [31:0] mmu_data_out;
  logic        mmu_ready;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_signed, d_width, d_addr, d_wdata,
           mmu_data_out, mmu_ready,
    output if_ack, if_rdata, d_ack, d_rdata, err,
           mmu_write_enable, mmu_read_enable, mmu_signed, mmu_width,
           mmu_address, mmu_data_in
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_signed, d_width, d_addr, d_wdata,
           mmu_data_out, mmu_ready,
    input  if_ack, if_rdata, d_ack, d_rdata, err,
           mmu_write_enable, mmu_read_enable, mmu_signed, mmu_width,
           mmu_address, mmu_data_in
  );
endinterface

// File: rtl/mmu_arbiter.sv
// Shares one mmu between fetch and data ports: one transaction at a time, data-priority with a
// starvation bound, registered one-cycle acks; requests are only looked at in IDLE.
module mmu_arbiter #(
  parameter int READ_SETTLE     = 2,
  parameter int MAX_DATA_STREAK = 4,
  parameter int TIMEOUT         = 15
) (
  input logic          clk_i,
  input logic          rst_ni,
  mmu_arbiter_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_WAIT_BUSY, S_WAIT_READY, S_SETTLE, S_RESP
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  streak_q, streak_d;
  logic [7:0]  timer_q, timer_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        is_d_q, is_d_d;
  logic        we_q, we_d;
  logic        wen_q, wen_d, ren_q, ren_d;
  logic        sgn_q, sgn_d;
  logic [1:0]  width_q, width_d;
  logic [31:0] addr_q, addr_d, din_q, din_d;
  logic        if_ack_q, if_ack_d, d_ack_q, d_ack_d, err_q, err_d;
  logic [31:0] if_rdata_q, if_rdata_d, d_rdata_q, d_rdata_d;

  logic       grant_w, pick_if_w, waiting_w, timeout_w, done_w, settle_start_w;
  logic       capture_w, resp_go_w;
  logic [7:0] timer_inc_w;

  assign grant_w     = (state_q == S_IDLE) && bus.mmu_ready && (bus.if_req || bus.d_req);
  assign pick_if_w   = !bus.d_req || (bus.if_req && (streak_q >= 8'(MAX_DATA_STREAK)));
  assign waiting_w   = (state_q == S_WAIT_BUSY) || (state_q == S_WAIT_READY) || (state_q == S_SETTLE);
  assign timer_inc_w = timer_q + 8'd1;
  assign timeout_w   = waiting_w && (timer_inc_w == 8'(TIMEOUT));
  assign settle_start_w = (state_q == S_WAIT_READY) && bus.mmu_ready && !we_q && (READ_SETTLE != 0);
  // Stores and zero-settle reads finish straight out of WAIT_READY; reads otherwise end in SETTLE.
  assign done_w = ((state_q == S_WAIT_READY) && bus.mmu_ready && (we_q || (READ_SETTLE == 0)))
               || ((state_q == S_SETTLE) && (cnt_q == 8'd1));
  assign resp_go_w = timeout_w || done_w;
  assign capture_w = done_w && !timeout_w && !we_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= S_IDLE;
      streak_q   <= '0;
      timer_q    <= '0;
      cnt_q      <= '0;
      is_d_q     <= 1'b0;
      we_q       <= 1'b0;
      wen_q      <= 1'b0;
      ren_q      <= 1'b0;
      sgn_q      <= 1'b0;
      width_q    <= '0;
      addr_q     <= '0;
      din_q      <= '0;
      if_ack_q   <= 1'b0;
      d_ack_q    <= 1'b0;
      err_q      <= 1'b0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      streak_q   <= streak_d;
      timer_q    <= timer_d;
      cnt_q      <= cnt_d;
      is_d_q     <= is_d_d;
      we_q       <= we_d;
      wen_q      <= wen_d;
      ren_q      <= ren_d;
      sgn_q      <= sgn_d;
      width_q    <= width_d;
      addr_q     <= addr_d;
      din_q      <= din_d;
      if_ack_q   <= if_ack_d;
      d_ack_q    <= d_ack_d;
      err_q      <= err_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:       if (grant_w) state_d = S_ISSUE;
      S_ISSUE:      state_d = S_WAIT_BUSY;
      S_WAIT_BUSY:  if (timeout_w) state_d = S_RESP;
                    else if (!bus.mmu_ready) state_d = S_WAIT_READY;
      S_WAIT_READY: if (resp_go_w) state_d = S_RESP;
                    else if (settle_start_w) state_d = S_SETTLE;
      S_SETTLE:     if (resp_go_w) state_d = S_RESP;
      S_RESP:       state_d = S_IDLE;
      default:      state_d = S_IDLE;
    endcase
  end

  always_comb begin
    streak_d   = streak_q;
    timer_d    = timer_q;
    cnt_d      = cnt_q;
    is_d_d     = is_d_q;
    we_d       = we_q;
    wen_d      = 1'b0;
    ren_d      = 1'b0;
    sgn_d      = sgn_q;
    width_d    = width_q;
    addr_d     = addr_q;
    din_d      = din_q;
    if_ack_d   = 1'b0;
    d_ack_d    = 1'b0;
    err_d      = 1'b0;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;

    // Enables are loaded on the grant edge so they are high for the ISSUE cycle only.
    if (grant_w) begin
      if (pick_if_w) begin
        is_d_d   = 1'b0;
        we_d     = 1'b0;
        ren_d    = 1'b1;
        sgn_d    = 1'b0;
        width_d  = 2'd3;
        addr_d   = bus.if_addr;
        din_d    = '0;
        streak_d = '0;
      end else begin
        is_d_d  = 1'b1;
        we_d    = bus.d_we;
        wen_d   = bus.d_we;
        ren_d   = !bus.d_we;
        sgn_d   = bus.d_signed;
        width_d = bus.d_width;
        addr_d  = bus.d_addr;
        din_d   = bus.d_wdata;
        if (!bus.if_req)
          streak_d = '0;
        else if (streak_q < 8'(MAX_DATA_STREAK))
          streak_d = streak_q + 8'd1;
      end
    end

    if (state_q == S_ISSUE) timer_d = '0;
    if (waiting_w) timer_d = timer_inc_w;
    if (settle_start_w) cnt_d = 8'(READ_SETTLE);
    if (state_q == S_SETTLE) cnt_d = cnt_q - 8'd1;

    if (resp_go_w) begin
      err_d = timeout_w;
      if (is_d_q) begin
        d_ack_d   = 1'b1;
        d_rdata_d = capture_w ? bus.mmu_data_out : '0;
      end else begin
        if_ack_d   = 1'b1;
        if_rdata_d = capture_w ? bus.mmu_data_out : '0;
      end
    end
  end

  assign bus.if_ack           = if_ack_q;
  assign bus.if_rdata         = if_rdata_q;
  assign bus.d_ack            = d_ack_q;
  assign bus.d_rdata          = d_rdata_q;
  assign bus.err              = err_q;
  assign bus.mmu_write_enable = wen_q;
  assign bus.mmu_read_enable  = ren_q;
  assign bus.mmu_signed       = sgn_q;
  assign bus.mmu_width        = width_q;
  assign bus.mmu_address      = addr_q;
  assign bus.mmu_data_in      = din_q;

endmodule
